// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared definitions for the i2c transaction arbiter:
//   - arb_state_t            : arbiter FSM state encoding (IDLE=0 .. RESP=5)
//   - DEFAULT_TIMEOUT_CYCLES : default per-wait-state timeout in clk cycles
//   - TIMER_WIDTH            : width of the wait-state timeout counter
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    RESP      = 3'd5
  } arb_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65535;
  localparam int unsigned TIMER_WIDTH            = 16;

endpackage

// File: rtl/i2c_xacn_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Scans req_vec starting at
// index last+1 (wrapping modulo NUM_REQ) and returns the first set index.
// Ports:
//   req_vec [NUM_REQ] in  : candidate request vector
//   last    [IW]      in  : index granted most recently
//   valid             out : at least one candidate present
//   idx     [IW]      out : chosen index (0 when !valid)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  always_comb begin
    int unsigned w_pos;
    w_pos = 0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_pos = int'(last) + k;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      if (!valid && req_vec[IW'(w_pos)]) begin
        valid = 1'b1;
        idx   = IW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/i2c_xacn_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_xacn_arbiter
// Round-robin scheduler sharing one i2c master/slave block among NUM_REQ
// requesters. One register transaction at a time: grant, drive command
// fields with i2c_enable high, strobe write_en/read_en, wait for busy/done
// (with timeout), then return data/error with a one-cycle ack.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   arb_en                : gate for new grants (in-flight work completes)
//   req/req_write/req_mode: per-requester request level, direction, mode
//   req_chip_addr/req_reg_addr/req_wdata : flattened per-requester fields
//   ack                   : one-hot completion pulse
//   rsp_rdata/rsp_err/rsp_timeout : response, valid while ack is high
//   i2c_*  (out)          : command interface to the i2c block
//   i2c_done/busy/data_out/status (in) : completion interface from i2c
//   arb_busy              : high in every state except IDLE
// ---------------------------------------------------------------------------
module i2c_xacn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_BYTES     = 1,
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned REG_ADDR_WIDTH = 8 * ADDR_BYTES,
  parameter int unsigned DW             = 8 * DATA_BYTES,
  parameter int unsigned ST_WIDTH       = 1 + ADDR_BYTES + DATA_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              arb_en,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ-1:0]                req_mode,
  input  logic [7*NUM_REQ-1:0]              req_chip_addr,
  input  logic [REG_ADDR_WIDTH*NUM_REQ-1:0] req_reg_addr,
  input  logic [DW*NUM_REQ-1:0]             req_wdata,
  output logic [NUM_REQ-1:0]                ack,
  output logic [DW-1:0]                     rsp_rdata,
  output logic                              rsp_err,
  output logic                              rsp_timeout,
  output logic                              i2c_enable,
  output logic [6:0]                        i2c_chip_addr,
  output logic [REG_ADDR_WIDTH-1:0]         i2c_reg_addr,
  output logic [DW-1:0]                     i2c_data_in,
  output logic                              i2c_write_en,
  output logic                              i2c_write_mode,
  output logic                              i2c_read_en,
  input  logic                              i2c_done,
  input  logic                              i2c_busy,
  input  logic [DW-1:0]                     i2c_data_out,
  input  logic [ST_WIDTH-1:0]               i2c_status,
  output logic                              arb_busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_t                r_state;
  logic [IW-1:0]             r_last;
  logic [IW-1:0]             r_idx;
  logic [NUM_REQ-1:0]        r_served;
  logic [NUM_REQ-1:0]        r_ack;
  logic                      r_write;
  logic                      r_mode;
  logic [6:0]                r_chip;
  logic [REG_ADDR_WIDTH-1:0] r_reg;
  logic [DW-1:0]             r_wdata;
  logic [DW-1:0]             r_rdata;
  logic                      r_err;
  logic                      r_timeout;
  logic                      r_enable;
  logic                      r_write_en;
  logic                      r_read_en;
  logic [TIMER_WIDTH-1:0]    r_cnt;

  logic [NUM_REQ-1:0]        w_elig;
  logic                      w_valid;
  logic [IW-1:0]             w_idx;
  logic [NUM_REQ-1:0]        w_idx_onehot;
  logic [6:0]                w_sel_chip;
  logic [REG_ADDR_WIDTH-1:0] w_sel_reg;
  logic [DW-1:0]             w_sel_wdata;
  logic                      w_sel_write;
  logic                      w_sel_mode;
  logic                      w_expired;

  // The requester acked last cycle is masked for one IDLE cycle so a
  // requester that drops req one cycle late is not granted twice.
  assign w_elig    = req & ~r_served;
  assign w_expired = (r_cnt == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_vec (w_elig),
    .last    (r_last),
    .valid   (w_valid),
    .idx     (w_idx)
  );

  always_comb begin
    w_sel_chip   = '0;
    w_sel_reg    = '0;
    w_sel_wdata  = '0;
    w_sel_write  = 1'b0;
    w_sel_mode   = 1'b0;
    w_idx_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_sel_chip  = req_chip_addr[7*i +: 7];
        w_sel_reg   = req_reg_addr[REG_ADDR_WIDTH*i +: REG_ADDR_WIDTH];
        w_sel_wdata = req_wdata[DW*i +: DW];
        w_sel_write = req_write[i];
        w_sel_mode  = req_mode[i];
      end
      w_idx_onehot[i] = (r_idx == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= IW'(NUM_REQ - 1);
      r_idx      <= '0;
      r_served   <= '0;
      r_ack      <= '0;
      r_write    <= 1'b0;
      r_mode     <= 1'b0;
      r_chip     <= '0;
      r_reg      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
      r_enable   <= 1'b0;
      r_write_en <= 1'b0;
      r_read_en  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_ack      <= '0;
      r_served   <= '0;
      r_write_en <= 1'b0;
      r_read_en  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (arb_en && w_valid) begin
            r_idx    <= w_idx;
            r_chip   <= w_sel_chip;
            r_reg    <= w_sel_reg;
            r_wdata  <= w_sel_wdata;
            r_write  <= w_sel_write;
            r_mode   <= w_sel_mode;
            r_enable <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_write_en <= r_write;
          r_read_en  <= ~r_write;
          r_state    <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // Priority: done, then busy, then timeout.
          if (i2c_done) begin
            r_rdata   <= r_write ? '0 : i2c_data_out;
            r_err     <= |i2c_status;
            r_timeout <= 1'b0;
            r_ack     <= w_idx_onehot;
            r_state   <= RESP;
          end else if (i2c_busy) begin
            r_cnt   <= '0;
            r_state <= WAIT_DONE;
          end else if (w_expired) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_ack     <= w_idx_onehot;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (i2c_done) begin
            r_rdata   <= r_write ? '0 : i2c_data_out;
            r_err     <= |i2c_status;
            r_timeout <= 1'b0;
            r_ack     <= w_idx_onehot;
            r_state   <= RESP;
          end else if (w_expired) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            r_ack     <= w_idx_onehot;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_served  <= r_ack;
          r_last    <= r_idx;
          r_enable  <= 1'b0;
          r_rdata   <= '0;
          r_err     <= 1'b0;
          r_timeout <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_enable <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign ack            = r_ack;
  assign rsp_rdata      = r_rdata;
  assign rsp_err        = r_err;
  assign rsp_timeout    = r_timeout;
  assign i2c_enable     = r_enable;
  assign i2c_chip_addr  = r_chip;
  assign i2c_reg_addr   = r_reg;
  assign i2c_data_in    = r_wdata;
  assign i2c_write_en   = r_write_en;
  assign i2c_write_mode = r_mode;
  assign i2c_read_en    = r_read_en;
  assign arb_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_i2c_xacn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_xacn_arbiter
// Self-checking bench for i2c_xacn_arbiter (NUM_REQ=4, 1 address byte,
// 4 data bytes, TIMEOUT_CYCLES=64). The bench plays both the requesters and
// the i2c block; a transaction-level model predicts grant order and the
// response of each transaction.
// ---------------------------------------------------------------------------
module tb_i2c_xacn_arbiter;

  localparam int NR  = 4;
  localparam int RW  = 8;
  localparam int DW  = 32;
  localparam int STW = 6;
  localparam int TMO = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              arb_en;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_write;
  logic [NR-1:0]     req_mode;
  logic [7*NR-1:0]   req_chip_addr;
  logic [RW*NR-1:0]  req_reg_addr;
  logic [DW*NR-1:0]  req_wdata;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              i2c_enable;
  logic [6:0]        i2c_chip_addr;
  logic [RW-1:0]     i2c_reg_addr;
  logic [DW-1:0]     i2c_data_in;
  logic              i2c_write_en;
  logic              i2c_write_mode;
  logic              i2c_read_en;
  logic              i2c_done;
  logic              i2c_busy;
  logic [DW-1:0]     i2c_data_out;
  logic [STW-1:0]    i2c_status;
  logic              arb_busy;

  // Requester fields
  logic [6:0]    chip [NR];
  logic [RW-1:0] rega [NR];
  logic [DW-1:0] wdat [NR];
  logic          wr   [NR];
  logic          mode [NR];

  // Transaction-level model state
  int            last_m;
  logic [NR-1:0] served_m;
  bit            just_acked;
  bit            en_drop;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_chip_addr = '0;
    req_reg_addr  = '0;
    req_wdata     = '0;
    req_write     = '0;
    req_mode      = '0;
    for (int i = 0; i < NR; i++) begin
      req_chip_addr[7*i +: 7]  = chip[i];
      req_reg_addr[RW*i +: RW] = rega[i];
      req_wdata[DW*i +: DW]    = wdat[i];
      req_write[i]             = wr[i];
      req_mode[i]              = mode[i];
    end
  end

  i2c_xacn_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_BYTES     (1),
    .DATA_BYTES     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .arb_en         (arb_en),
    .req            (req),
    .req_write      (req_write),
    .req_mode       (req_mode),
    .req_chip_addr  (req_chip_addr),
    .req_reg_addr   (req_reg_addr),
    .req_wdata      (req_wdata),
    .ack            (ack),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .rsp_timeout    (rsp_timeout),
    .i2c_enable     (i2c_enable),
    .i2c_chip_addr  (i2c_chip_addr),
    .i2c_reg_addr   (i2c_reg_addr),
    .i2c_data_in    (i2c_data_in),
    .i2c_write_en   (i2c_write_en),
    .i2c_write_mode (i2c_write_mode),
    .i2c_read_en    (i2c_read_en),
    .i2c_done       (i2c_done),
    .i2c_busy       (i2c_busy),
    .i2c_data_out   (i2c_data_out),
    .i2c_status     (i2c_status),
    .arb_busy       (arb_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {ack, rsp_err, rsp_timeout, i2c_enable, i2c_write_en,
                        i2c_write_mode, i2c_read_en, arb_busy, i2c_chip_addr,
                        i2c_reg_addr}, 64'h0);
    chk({tag, "_rdata"}, rsp_rdata, 64'h0);
    chk({tag, "_wdata"}, i2c_data_in, 64'h0);
  endtask

  task automatic set_fields(input int i, input bit w);
    chip[i] = 7'($urandom);
    rega[i] = 8'($urandom);
    wdat[i] = $urandom;
    wr[i]   = w;
    mode[i] = 1'($urandom);
  endtask

  // First requester in e found scanning from last+1 modulo NR, or -1.
  function automatic int pick(input logic [NR-1:0] e, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (e[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  // One whole transaction, entered and left at an IDLE-cycle negedge.
  // busy_en: i2c holds busy from the first wait cycle until done.
  // done_at: wait-cycle offset of the done pulse (-1 = never).
  task automatic xact(input bit busy_en, input int done_at, input logic [DW-1:0] dout,
                      input logic [STW-1:0] st, input bit keep, input logic [NR-1:0] add,
                      input logic [NR-1:0] late_drop);
    int            g;
    int            tries;
    int            deadline;
    int            resp_t;
    bit            tmo;
    logic [NR-1:0] elig;
    g     = -1;
    tries = 0;
    while (g < 0 && tries < 8) begin
      elig = arb_en ? (req & ~(just_acked ? served_m : '0)) : '0;
      g    = pick(elig, last_m);
      if (g < 0) begin
        @(negedge clk);
        just_acked = 0;
        tries++;
        chk("idle_hold", arb_busy, 0);
      end
    end
    n_tests++;
    assert (g >= 0) else begin
      n_fail++;
      $error("FAIL grant_wait: observed no eligible request expected a grant");
    end
    if (g < 0) return;

    @(negedge clk);  // SETUP
    just_acked = 0;
    chk("setup_enable", i2c_enable, 1);
    chk("setup_busy", arb_busy, 1);
    chk("setup_chip", i2c_chip_addr, chip[g]);
    chk("setup_reg", i2c_reg_addr, rega[g]);
    chk("setup_wdata", i2c_data_in, wdat[g]);
    chk("setup_mode", i2c_write_mode, mode[g]);
    chk("setup_strobes", {i2c_write_en, i2c_read_en}, 2'b00);
    req = req & ~late_drop;
    if (en_drop) arb_en = 1'b0;

    @(negedge clk);  // ISSUE
    chk("issue_wr", i2c_write_en, wr[g]);
    chk("issue_rd", i2c_read_en, !wr[g]);

    deadline = (busy_en ? 1 : 0) + TMO - 1;
    tmo      = !(done_at >= 0 && done_at <= deadline);
    resp_t   = tmo ? deadline + 1 : done_at + 1;
    for (int t = 0; t < resp_t; t++) begin
      @(negedge clk);
      i2c_busy     = busy_en && (done_at < 0 || t <= done_at);
      i2c_done     = (t == done_at);
      i2c_data_out = (t == done_at) ? dout : $urandom;
      i2c_status   = (t == done_at) ? st : STW'($urandom);
      chk("wait_ack", ack, 0);
      chk("wait_enable", i2c_enable, 1);
      chk("wait_strobes", {i2c_write_en, i2c_read_en}, 2'b00);
    end

    @(negedge clk);  // RESP
    i2c_busy = 1'b0;
    i2c_done = 1'b0;
    chk("resp_ack", ack, NR'(1) << g);
    chk("resp_rdata", rsp_rdata, (tmo || wr[g]) ? 32'h0 : dout);
    chk("resp_err", rsp_err, tmo ? 1'b1 : |st);
    chk("resp_timeout", rsp_timeout, tmo);
    chk("resp_enable", i2c_enable, 1);
    req        = (keep ? req : (req & ~(NR'(1) << g))) | add;
    last_m     = g;
    served_m   = NR'(1) << g;
    just_acked = 1;

    @(negedge clk);  // IDLE
    chk("idle_enable", i2c_enable, 0);
    chk("idle_ack", ack, 0);
  endtask

  initial begin
    logic [NR-1:0]  add;
    logic [STW-1:0] st;
    bit             ben;
    int             dat;

    reset        = 1'b1;
    arb_en       = 1'b1;
    req          = '0;
    i2c_done     = 1'b0;
    i2c_busy     = 1'b0;
    i2c_data_out = '0;
    i2c_status   = '0;
    en_drop      = 0;
    for (int i = 0; i < NR; i++) set_fields(i, 0);
    last_m     = NR - 1;
    served_m   = '0;
    just_acked = 0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Round-robin with all requests held: order 0,1,2,3,0
    for (int i = 0; i < NR; i++) set_fields(i, 1'($urandom));
    req = 4'hF;
    for (int n = 0; n < 4; n++) xact(1, 1, $urandom, '0, 1, '0, '0);
    xact(1, 1, $urandom, '0, 0, '0, '0);

    // Served mask: requester 2 holds req one cycle past its ack
    xact(1, 1, $urandom, '0, 0, '0, '0);
    xact(1, 1, $urandom, '0, 1, '0, '0);
    xact(1, 1, $urandom, '0, 0, '0, 4'b0100);

    // Single read
    set_fields(0, 0);
    chip[0] = 7'h50;
    rega[0] = 8'h10;
    req     = 4'b0001;
    xact(1, 20, 32'hDEADBEEF, '0, 0, '0, '0);

    // NACK on a write
    set_fields(1, 1);
    req = 4'b0010;
    xact(1, 3, $urandom, 6'h02, 0, '0, '0);

    // Timeouts in WAIT_BUSY and WAIT_DONE
    set_fields(2, 0);
    req = 4'b0100;
    xact(0, -1, $urandom, '0, 0, '0, '0);
    set_fields(3, 0);
    req = 4'b1000;
    xact(1, -1, $urandom, '0, 0, '0, '0);

    // done arriving on the last cycle before timeout
    set_fields(0, 0);
    req = 4'b0001;
    xact(0, TMO - 1, $urandom, '0, 0, '0, '0);
    set_fields(1, 0);
    req = 4'b0010;
    xact(1, TMO, $urandom, 6'h01, 0, '0, '0);

    // Fast completion, and done together with busy
    set_fields(2, 0);
    req = 4'b0100;
    xact(0, 0, $urandom, '0, 0, '0, '0);
    set_fields(3, 0);
    req = 4'b1000;
    xact(1, 0, $urandom, '0, 0, '0, '0);

    // Reset in WAIT_DONE
    @(negedge clk);
    just_acked = 0;
    chk("pre_rst_idle", arb_busy, 0);
    set_fields(0, 0);
    req = 4'b0001;
    @(negedge clk);
    chk("rst_setup", i2c_enable, 1);
    @(negedge clk);
    @(negedge clk);
    i2c_busy = 1'b1;
    @(negedge clk);
    chk("rst_wait_done", arb_busy, 1);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    chk_all_zero("mid_rst");
    reset    = 1'b0;
    i2c_busy = 1'b0;
    @(negedge clk);
    chk("post_rst_ack", ack, 0);
    chk("post_rst_enable", i2c_enable, 0);
    last_m     = NR - 1;
    served_m   = '0;
    just_acked = 0;
    for (int i = 0; i < NR; i++) set_fields(i, 1'($urandom));
    req = 4'hF;
    xact(1, 2, $urandom, '0, 0, '0, '0);

    // arb_en gating
    arb_en = 1'b0;
    set_fields(0, 0);
    req = 4'hF;
    repeat (6) begin
      @(negedge clk);
      chk("gate_busy", arb_busy, 0);
      chk("gate_enable", i2c_enable, 0);
    end
    just_acked = 0;
    arb_en     = 1'b1;
    en_drop    = 1;
    xact(1, 4, $urandom, 6'h04, 0, '0, '0);
    en_drop = 0;
    repeat (4) begin
      @(negedge clk);
      chk("gate2_busy", arb_busy, 0);
    end
    just_acked = 0;
    arb_en     = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      add = NR'($urandom) & ~req;
      if ($countones(req) <= 1 && add == '0) add = ~req;
      for (int i = 0; i < NR; i++) if (add[i]) set_fields(i, 1'($urandom));
      ben = 1'($urandom);
      dat = $urandom_range(0, 10);
      if ($urandom_range(0, 9) == 0) dat = -1;
      st  = ($urandom_range(0, 1) == 0) ? '0 : STW'($urandom);
      xact(ben, dat, $urandom, st, 0, add, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
